gelato_fetch_scheduler: RTL and testbench



---
 rtl/gelato_fetch_scheduler_pkg.sv | 17 +
 rtl/gelato_rr_arbiter.sv | 30 +++
 rtl/gelato_fetch_scheduler.sv | 134 +++++++++++++
 tb/tb_gelato_fetch_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/gelato_fetch_scheduler_pkg.sv
// Shared types for the gelato warp fetch/issue schedulers.
package gelato_types;

    localparam int WARP_NUM_DEF        = 4;
    localparam int PC_WIDTH_DEF        = 32;
    localparam int SPLIT_NUM_WIDTH_DEF = 3;

    typedef logic [$clog2(WARP_NUM_DEF)-1:0] warp_num_t;
    typedef logic [PC_WIDTH_DEF-1:0]         pc_t;
    typedef logic [SPLIT_NUM_WIDTH_DEF-1:0]  split_num_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ISSUED = 1'b1
    } warp_state_e;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i.
module gelato_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          grant_valid_o,
    output logic [IW-1:0] grant_idx_o
);

    logic [IW-1:0] idx_s;

    // Scan from the farthest offset back to ptr_i so the nearest request wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        idx_s         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s = ptr_i + IW'(k);
            if (req_i[idx_s]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = idx_s;
            end else begin
                grant_valid_o = grant_valid_o;
            end
        end
    end

endmodule

// File: rtl/gelato_fetch_scheduler.sv
// Warp fetch scheduler: round-robin picks one idle, valid warp per cycle and parks
// it until decode re-activates it, keeping one instruction per warp in flight.
module gelato_fetch_scheduler
    import gelato_types::*;
#(
    parameter int WARP_NUM        = WARP_NUM_DEF,
    parameter int PC_WIDTH        = PC_WIDTH_DEF,
    parameter int SPLIT_NUM_WIDTH = SPLIT_NUM_WIDTH_DEF,
    parameter int WW              = $clog2(WARP_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rdy,
    input  logic [WARP_NUM-1:0]                 pc_valid,
    input  logic [WARP_NUM*PC_WIDTH-1:0]        pc,
    input  logic [WARP_NUM*SPLIT_NUM_WIDTH-1:0] split_table_num,
    input  logic                                activate_valid,
    input  logic [WW-1:0]                       activate_warp_num,
    output logic                                fetch_valid,
    input  logic                                fetch_ready,
    output logic [WW-1:0]                       fetch_warp_num,
    output logic [PC_WIDTH-1:0]                 fetch_pc,
    output logic [SPLIT_NUM_WIDTH-1:0]          fetch_split_num,
    output logic [31:0]                         fetch_count
);

    warp_state_e                state_q     [WARP_NUM];
    warp_state_e                state_d     [WARP_NUM];
    warp_state_e                state_act_s [WARP_NUM];
    logic [WARP_NUM-1:0]        eligible_s;
    logic [WW-1:0]              rr_ptr_q, rr_ptr_d;
    logic                       valid_q, valid_d;
    logic [WW-1:0]              warp_q, warp_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic [SPLIT_NUM_WIDTH-1:0] split_q, split_d;
    logic [31:0]                count_q, count_d;
    logic                       load_s;
    logic                       accept_s;
    logic                       grant_valid_s;
    logic [WW-1:0]              grant_idx_s;

    // Activation is applied before the scan so a released warp competes this cycle.
    always_comb begin
        for (int i = 0; i < WARP_NUM; i++) begin
            state_act_s[i] = state_q[i];
        end
        if (activate_valid) begin
            state_act_s[activate_warp_num] = IDLE;
        end else begin
            state_act_s[0] = state_q[0];
        end
        for (int i = 0; i < WARP_NUM; i++) begin
            eligible_s[i] = pc_valid[i] && (state_act_s[i] == IDLE);
        end
    end

    gelato_rr_arbiter #(
        .N  (WARP_NUM),
        .IW (WW)
    ) u_arb (
        .req_i         (eligible_s),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid_s),
        .grant_idx_o   (grant_idx_s)
    );

    assign load_s   = !valid_q || fetch_ready;
    assign accept_s = valid_q && fetch_ready;

    // Next-state: load the output register, park the winner, advance the pointer.
    always_comb begin
        for (int i = 0; i < WARP_NUM; i++) begin
            state_d[i] = state_q[i];
        end
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        warp_d   = warp_q;
        pc_d     = pc_q;
        split_d  = split_q;
        count_d  = count_q;
        if (rdy) begin
            for (int i = 0; i < WARP_NUM; i++) begin
                state_d[i] = state_act_s[i];
            end
            count_d = count_q + {31'b0, accept_s};
            if (load_s && grant_valid_s) begin
                valid_d              = 1'b1;
                warp_d               = grant_idx_s;
                pc_d                 = pc[grant_idx_s*PC_WIDTH +: PC_WIDTH];
                split_d              = split_table_num[grant_idx_s*SPLIT_NUM_WIDTH +: SPLIT_NUM_WIDTH];
                state_d[grant_idx_s] = ISSUED;
                rr_ptr_d             = grant_idx_s + WW'(1);
            end else if (load_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // State, pointer, output register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WARP_NUM; i++) begin
                state_q[i] <= IDLE;
            end
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            warp_q   <= '0;
            pc_q     <= '0;
            split_q  <= '0;
            count_q  <= 32'd0;
        end else begin
            for (int i = 0; i < WARP_NUM; i++) begin
                state_q[i] <= state_d[i];
            end
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            warp_q   <= warp_d;
            pc_q     <= pc_d;
            split_q  <= split_d;
            count_q  <= count_d;
        end
    end

    assign fetch_valid     = valid_q;
    assign fetch_warp_num  = warp_q;
    assign fetch_pc        = pc_q;
    assign fetch_split_num = split_q;
    assign fetch_count     = count_q;

endmodule

// File: tb/tb_gelato_fetch_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a reference model.
module tb_gelato_fetch_scheduler;

    localparam int WN = 4;
    localparam int PW = 32;
    localparam int SW = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic [WN-1:0]    pc_valid;
    logic [WN*PW-1:0] pc;
    logic [WN*SW-1:0] split_table_num;
    logic             activate_valid;
    logic [1:0]       activate_warp_num;
    logic             fetch_valid;
    logic             fetch_ready;
    logic [1:0]       fetch_warp_num;
    logic [PW-1:0]    fetch_pc;
    logic [SW-1:0]    fetch_split_num;
    logic [31:0]      fetch_count;

    always #5 clk = ~clk;

    gelato_fetch_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .rdy               (rdy),
        .pc_valid          (pc_valid),
        .pc                (pc),
        .split_table_num   (split_table_num),
        .activate_valid    (activate_valid),
        .activate_warp_num (activate_warp_num),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_warp_num    (fetch_warp_num),
        .fetch_pc          (fetch_pc),
        .fetch_split_num   (fetch_split_num),
        .fetch_count       (fetch_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: which warps are parked, where the rotation resumes, what is offered.
    bit          m_parked [WN];
    int          m_next;
    bit          m_offer;
    int          m_warp;
    logic [31:0] m_pc;
    logic [2:0]  m_split;
    logic [31:0] m_count;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit found;
        int w;
        if (rst) begin
            foreach (m_parked[i]) m_parked[i] = 1'b0;
            m_next = 0; m_offer = 1'b0; m_warp = 0; m_pc = '0; m_split = '0; m_count = '0;
        end else if (rdy) begin
            if (activate_valid) m_parked[activate_warp_num] = 1'b0;
            if (m_offer && fetch_ready) m_count = m_count + 1;
            if (!m_offer || fetch_ready) begin
                found = 1'b0;
                for (int k = 0; k < WN; k++) begin
                    w = (m_next + k) % WN;
                    if (!found && pc_valid[w] && !m_parked[w]) begin
                        found = 1'b1;
                        m_offer = 1'b1; m_warp = w;
                        m_pc = pc[w*PW +: PW]; m_split = split_table_num[w*SW +: SW];
                        m_parked[w] = 1'b1;
                        m_next = (w + 1) % WN;
                    end
                end
                if (!found) m_offer = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("valid", {31'b0, fetch_valid}, {31'b0, m_offer});
        check_eq("count", fetch_count, m_count);
        if (m_offer) begin
            check_eq("warp", {30'b0, fetch_warp_num}, m_warp);
            check_eq("pc", fetch_pc, m_pc);
            check_eq("split", {29'b0, fetch_split_num}, {29'b0, m_split});
        end
    endtask

    int          seq [5];
    logic [31:0] c0;

    initial begin
        rst = 1'b1; rdy = 1'b1; pc_valid = '0; activate_valid = 1'b0; activate_warp_num = '0;
        fetch_ready = 1'b0;
        for (int i = 0; i < WN; i++) begin
            pc[i*PW +: PW]              = 32'h100 * (i + 1);
            split_table_num[i*SW +: SW] = SW'(i + 1);
        end
        #1;
        step(); step();
        check_eq("rst_valid", {31'b0, fetch_valid}, 32'd0);
        check_eq("rst_count", fetch_count, 32'd0);

        // Release reset with every warp valid: warp 0 goes first.
        rst = 1'b0; pc_valid = 4'b1111;
        step();
        check_eq("first_warp", {30'b0, fetch_warp_num}, 32'd0);
        check_eq("first_pc", fetch_pc, 32'h100);

        // Round robin, each warp activated the cycle after it was offered.
        fetch_ready = 1'b1;
        seq[0] = fetch_warp_num;
        for (int n = 1; n < 5; n++) begin
            activate_valid = 1'b1; activate_warp_num = 2'(m_warp);
            step();
            seq[n] = fetch_warp_num;
        end
        activate_valid = 1'b1; activate_warp_num = 2'(m_warp);
        step();
        activate_valid = 1'b0;
        for (int n = 0; n < 5; n++) check_eq("rr_seq", seq[n], (n == 4) ? 0 : n);
        check_eq("rr_count", fetch_count, 32'd5);

        // Stall with warp 2 pending.
        rst = 1'b1; step(); rst = 1'b0;
        pc_valid = 4'b0100; pc[2*PW +: PW] = 32'h0000_1000; fetch_ready = 1'b0;
        step();
        for (int n = 0; n < 5; n++) begin
            step();
            check_eq("stall_pc", fetch_pc, 32'h0000_1000);
            check_eq("stall_warp", {30'b0, fetch_warp_num}, 32'd2);
            check_eq("stall_count", fetch_count, 32'd0);
        end
        fetch_ready = 1'b1; pc_valid = 4'b0000;
        step();
        check_eq("stall_release_count", fetch_count, 32'd1);

        // Park warp 1 with no activate, then release it.
        pc_valid = 4'b0010;
        step(); step();
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("parked_valid", {31'b0, fetch_valid}, 32'd0);
        end
        activate_valid = 1'b1; activate_warp_num = 2'd1;
        step();
        activate_valid = 1'b0;
        check_eq("reactivated_warp", {30'b0, fetch_warp_num}, 32'd1);

        // Global freeze, then reset in the middle of a stall.
        c0 = fetch_count; rdy = 1'b0; fetch_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            step();
            check_eq("freeze_count", fetch_count, c0);
            check_eq("freeze_valid", {31'b0, fetch_valid}, 32'd1);
        end
        rdy = 1'b1; fetch_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        check_eq("rst_mid_valid", {31'b0, fetch_valid}, 32'd0);
        rst = 1'b0;

        // Randomized traffic, including activates of idle warps and occasional resets.
        for (int n = 0; n < 600; n++) begin
            rdy               = ($urandom % 8) != 0;
            fetch_ready       = ($urandom % 4) != 0;
            pc_valid          = 4'($urandom);
            activate_valid    = ($urandom % 2) != 0;
            activate_warp_num = 2'($urandom);
            rst               = ($urandom % 150) == 0;
            for (int i = 0; i < WN; i++) begin
                pc[i*PW +: PW]              = $urandom;
                split_table_num[i*SW +: SW] = 3'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
